// File: rtl/grover_diffusion_stream.sv
// grover_diffusion_stream
//
// Streaming Grover diffusion stage. A frame of 2**NUM_BIT signed fixed-point
// amplitudes arrives LANES per beat and is buffered. While loading, the
// amplitude at the oracle index can be phase-inverted. Once the frame is
// complete, twice the mean is formed and the frame is replayed as
// 2*mean - a[k], with optional saturation to the amplitude width.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active low
//   oracle_en  : negate the amplitude at oracle_idx while loading (sampled on beat 0)
//   oracle_idx : marked basis state (sampled on beat 0)
//   in_valid   : input beat valid
//   in_ready   : input beat accepted (LOAD state only)
//   in_data    : LANES amplitudes, lane j at [j*FPB +: FPB], index beat*LANES+j
//   out_valid  : output beat valid
//   out_ready  : downstream accepts output beat
//   out_data   : LANES diffused amplitudes, same packing as in_data
//   out_last   : final output beat of the frame
//   out_sat    : some lane of the current frame was clamped (SAT=1), sticky per frame

module grover_diffusion_stream #(
    parameter int NUM_BIT        = 3,
    parameter int FIXEDPOINT_BIT = 24,
    parameter int LANES          = 2,
    parameter int SAT            = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              oracle_en,
    input  logic [NUM_BIT-1:0]                oracle_idx,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*FIXEDPOINT_BIT-1:0]   in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*FIXEDPOINT_BIT-1:0]   out_data,
    output logic                              out_last,
    output logic                              out_sat
);

    localparam int FPB        = FIXEDPOINT_BIT;
    localparam int NUM_SAMPLE = 1 << NUM_BIT;
    localparam int NUM_BEATS  = NUM_SAMPLE / LANES;
    localparam int CW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SW         = FPB + NUM_BIT;
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MEAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            rd_row;
    logic signed [SW-1:0]     sum;
    logic [FPB:0]             two_mean;
    logic                     orc_en_q;
    logic [NUM_BIT-1:0]       orc_idx_q;

    logic [LANES*FPB-1:0]     buf_mem [NUM_BEATS];

    // load path: oracle inversion and per-beat partial sum
    logic                     neg_en;
    logic [NUM_BIT-1:0]       neg_idx;
    logic [NUM_BIT-1:0]       base_idx;
    logic [FPB-1:0]           ld_lane;
    logic [LANES*FPB-1:0]     ld_row;
    logic [SW-1:0]            ld_sum;

    // drain path: diffusion and clamping of the current row
    logic [LANES*FPB-1:0]     rd_data;
    logic [FPB-1:0]           rd_lane;
    logic [FPB+1:0]           diff;
    logic [FPB-1:0]           res;
    logic [LANES*FPB-1:0]     dr_row;
    logic                     dr_sat;

    wire in_fire = in_valid && in_ready;

    // Beat 0 uses the live oracle inputs; later beats use the copy captured then.
    always_comb begin
        neg_en   = (cnt == '0) ? oracle_en  : orc_en_q;
        neg_idx  = (cnt == '0) ? oracle_idx : orc_idx_q;
        base_idx = NUM_BIT'(int'(cnt) * LANES);
        ld_row   = '0;
        ld_sum   = '0;
        ld_lane  = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            ld_lane = in_data[j*FPB +: FPB];
            // two's complement negation: the most negative code maps to itself
            if (neg_en && ((base_idx + NUM_BIT'(j)) == neg_idx))
                ld_lane = -ld_lane;
            ld_row[j*FPB +: FPB] = ld_lane;
            ld_sum = ld_sum + {{NUM_BIT{ld_lane[FPB-1]}}, ld_lane};
        end
    end

    always_comb begin
        rd_data = buf_mem[rd_row];
        dr_row  = '0;
        dr_sat  = 1'b0;
        rd_lane = '0;
        diff    = '0;
        res     = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            rd_lane = rd_data[j*FPB +: FPB];
            diff    = {two_mean[FPB], two_mean} - {{2{rd_lane[FPB-1]}}, rd_lane};
            // result fits FPB signed bits only when the top three bits agree
            if ((SAT != 0) && !((diff[FPB+1:FPB-1] == 3'b000) || (diff[FPB+1:FPB-1] == 3'b111))) begin
                res    = diff[FPB+1] ? {1'b1, {(FPB-1){1'b0}}} : {1'b0, {(FPB-1){1'b1}}};
                dr_sat = 1'b1;
            end else begin
                res = diff[FPB-1:0];
            end
            dr_row[j*FPB +: FPB] = res;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_fire)
            buf_mem[cnt] <= ld_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            cnt       <= '0;
            rd_row    <= '0;
            sum       <= '0;
            two_mean  <= '0;
            orc_en_q  <= 1'b0;
            orc_idx_q <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        sum <= sum + ld_sum;
                        if (cnt == '0) begin
                            orc_en_q  <= oracle_en;
                            orc_idx_q <= oracle_idx;
                        end
                        if (cnt == LAST_ROW) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= S_MEAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_MEAN: begin
                    // sum/NUM_SAMPLE*2, floor
                    two_mean <= (FPB+1)'(sum >>> (NUM_BIT - 1));
                    rd_row   <= '0;
                    state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    // output register refills whenever it is empty or being consumed
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_sat   <= 1'b0;
                            sum       <= '0;
                            in_ready  <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            out_data  <= dr_row;
                            out_valid <= 1'b1;
                            out_last  <= (rd_row == LAST_ROW);
                            if (dr_sat)
                                out_sat <= 1'b1;
                            if (rd_row != LAST_ROW)
                                rd_row <= rd_row + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_grover_diffusion_stream.sv
module tb_grover_diffusion_stream;

    localparam logic [23:0] A1   = 24'd1482910;
    localparam logic [23:0] LO   = 24'd741455;
    localparam logic [23:0] HI   = 24'd3707275;
    localparam logic [23:0] MAXP = 24'd8388607;
    localparam logic [23:0] MINN = 24'h800000;
    localparam logic [23:0] HALF = 24'd4194303;
    localparam logic [23:0] W7   = 24'd4194302;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         oracle_en;
    logic [2:0]   oracle_idx;
    logic         in_valid;
    logic [47:0]  in_data;
    logic         out_ready;

    logic         ir_a, ov_a, ol_a, os_a;
    logic [47:0]  od_a;
    logic         ir_b, ov_b, ol_b, os_b;
    logic [47:0]  od_b;

    logic         iv1, ir1, ov1, ol1, os1;
    logic [23:0]  id1, od1;
    logic         iv8, ir8, ov8, ol8, os8;
    logic [191:0] id8, od8;

    grover_diffusion_stream #(.NUM_BIT(3), .FIXEDPOINT_BIT(24), .LANES(2), .SAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .oracle_en(oracle_en), .oracle_idx(oracle_idx),
        .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a), .out_sat(os_a));

    grover_diffusion_stream #(.NUM_BIT(3), .FIXEDPOINT_BIT(24), .LANES(2), .SAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .oracle_en(oracle_en), .oracle_idx(oracle_idx),
        .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b), .out_sat(os_b));

    grover_diffusion_stream #(.NUM_BIT(3), .FIXEDPOINT_BIT(24), .LANES(1), .SAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .oracle_en(oracle_en), .oracle_idx(oracle_idx),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .out_sat(os1));

    grover_diffusion_stream #(.NUM_BIT(3), .FIXEDPOINT_BIT(24), .LANES(8), .SAT(1)) dut_l8 (
        .clk(clk), .rst_n(rst_n), .oracle_en(oracle_en), .oracle_idx(oracle_idx),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_last(ol8), .out_sat(os8));

    int tests = 0;
    int fails = 0;

    logic [23:0] amp  [8];
    logic [23:0] expa [8];
    logic [23:0] expb [8];
    logic [47:0] got_a [4];
    logic [47:0] got_b [4];
    logic        got_last [4];
    logic        got_sat_a, got_sat_b;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drives one LANES=2 frame into dut_a/dut_b; starts and ends on a falling edge
    task automatic send_frame(input bit gaps);
        int n;
        for (int b = 0; b < 4; b++) begin
            if (gaps && b > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = {amp[2*b+1], amp[2*b]};
            n = 0;
            while (!ir_a && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            // the oracle must have been captured with beat 0
            if (b == 0) oracle_idx = oracle_idx ^ 3'b011;
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input bit rnd);
        int beats, cyc;
        bit stalled;
        logic [47:0] prev;
        logic prevl;
        beats = 0; cyc = 0; stalled = 0; prev = '0; prevl = 1'b0;
        while (beats < 4 && cyc < 300) begin
            if (stalled) begin
                chk("stall_data", od_a, prev);
                chk("stall_last", ol_a, prevl);
            end
            chk("in_ready_busy", ir_a, 0);
            out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (ov_a && out_ready) begin
                got_a[beats]    = od_a;
                got_b[beats]    = od_b;
                got_last[beats] = ol_a;
                got_sat_a       = os_a;
                got_sat_b       = os_b;
                beats++;
                stalled = 0;
            end else begin
                stalled = ov_a;
                prev    = od_a;
                prevl   = ol_a;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("recv_beats", beats, 4);
        chk("in_ready_after", ir_a, 1);
        chk("out_valid_after", ov_a, 0);
        chk("out_sat_cleared", os_a, 0);
    endtask

    task automatic check_frame(input string tag, input logic sat_a, input logic sat_b);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_a%0d", tag, k), got_a[k/2][(k%2)*24 +: 24], expa[k]);
            chk($sformatf("%s_b%0d", tag, k), got_b[k/2][(k%2)*24 +: 24], expb[k]);
        end
        for (int b = 0; b < 4; b++)
            chk($sformatf("%s_last%0d", tag, b), got_last[b], (b == 3));
        chk({tag, "_sat_a"}, got_sat_a, sat_a);
        chk({tag, "_sat_b"}, got_sat_b, sat_b);
    endtask

    task automatic setup_test1();
        oracle_en  = 1'b1;
        oracle_idx = 3'd5;
        for (int k = 0; k < 8; k++) begin
            amp[k]  = A1;
            expa[k] = (k == 5) ? HI : LO;
            expb[k] = (k == 5) ? HI : LO;
        end
    endtask

    logic [191:0] exp8;
    int n;

    initial begin
        rst_n = 1'b0; oracle_en = 1'b0; oracle_idx = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        iv1 = 1'b0; id1 = '0; iv8 = 1'b0; id8 = '0;
        got_sat_a = 1'b0; got_sat_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_in_ready", ir_a, 1);
        chk("rst_out_data", od_a, 0);
        chk("rst_out_last", ol_a, 0);
        chk("rst_out_sat", os_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // test 1: oracle on index 5, latency
        setup_test1();
        send_frame(0);
        chk("lat_mean_valid", ov_a, 0);
        chk("lat_mean_ready", ir_a, 0);
        @(negedge clk);
        chk("lat_t1_valid", ov_a, 0);
        @(negedge clk);
        chk("lat_t2_valid", ov_a, 1);
        recv(0);
        check_frame("t1", 1'b0, 1'b0);

        // test 2: uniform frame is a fixed point
        oracle_en = 1'b0; oracle_idx = 3'd5;
        for (int k = 0; k < 8; k++) begin
            amp[k] = A1; expa[k] = A1; expb[k] = A1;
        end
        send_frame(0);
        recv(0);
        check_frame("t2", 1'b0, 1'b0);

        // test 3: saturation vs wrap
        oracle_en = 1'b0; oracle_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            amp[k]  = (k == 7) ? MINN : MAXP;
            expa[k] = (k == 7) ? MAXP : HALF;
            expb[k] = (k == 7) ? W7   : HALF;
        end
        send_frame(0);
        recv(0);
        check_frame("t3", 1'b1, 1'b0);

        // test 4: input gaps and random backpressure
        setup_test1();
        send_frame(1);
        recv(1);
        check_frame("t4", 1'b0, 1'b0);

        // test 5: reset in the middle of the drain
        setup_test1();
        send_frame(0);
        n = 0;
        while (!ov_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t5_valid", ov_a, 1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_row2", od_a, {HI, LO});
        chk("t5_row2_last", ol_a, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid_a", ov_a, 0);
        chk("t5_rst_valid_b", ov_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", ir_a, 1);
        setup_test1();
        send_frame(0);
        recv(0);
        check_frame("t5", 1'b0, 1'b0);

        // test 6a: LANES=8, whole frame in one beat
        oracle_en = 1'b1; oracle_idx = 3'd5;
        exp8 = '0;
        for (int k = 0; k < 8; k++) begin
            id8[k*24 +: 24]  = A1;
            exp8[k*24 +: 24] = (k == 5) ? HI : LO;
        end
        chk("l8_in_ready", ir8, 1);
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        chk("l8_lat_mean", ov8, 0);
        @(negedge clk);
        chk("l8_lat_t1", ov8, 0);
        @(negedge clk);
        chk("l8_valid", ov8, 1);
        chk("l8_data", od8, exp8);
        chk("l8_last", ol8, 1);
        chk("l8_sat", os8, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("l8_done_valid", ov8, 0);
        chk("l8_done_ready", ir8, 1);

        // test 6b: LANES=1, one amplitude per beat
        oracle_en = 1'b1; oracle_idx = 3'd5;
        for (int k = 0; k < 8; k++) begin
            iv1 = 1'b1;
            id1 = A1;
            @(negedge clk);
            if (k == 0) oracle_idx = 3'd2;
        end
        iv1 = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!ov1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("l1_valid", ov1, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("l1_data%0d", k), od1, (k == 5) ? HI : LO);
            chk($sformatf("l1_last%0d", k), ol1, (k == 7));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("l1_done_valid", ov1, 0);
        chk("l1_done_ready", ir1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
